// File: rtl/mem_boot_loader.sv
// ---------------------------------------------------------------------------
// mem_boot_loader
//
// Copies a boot image from a valid/ready word stream into memory over a
// valid/ready memory bus. It then reads the image back and compares both the
// write-side and read-side word sums against an expected checksum. The CPU
// reset (core_resetn) is released only when everything matches.
//
// Parameters
//   BASE_ADDR  byte address of word 0 of the image
//   MAX_WORDS  largest legal image length in words
//   TIMEOUT    maximum cycles a bus request may wait for mem_ready
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   start                       single-cycle load request
//   num_words, expected_sum     image length / checksum, captured on start
//   in_valid, in_ready, in_data image word stream (this block is the sink)
//   mem_valid, mem_instr,       memory bus request (this block initiates)
//   mem_ready
//   mem_addr, mem_wdata,        bus address, write data, byte strobes and
//   mem_wstrb, mem_rdata        read data
//   busy, done, error           load status
//   core_resetn                 CPU reset release, high only after success
// ---------------------------------------------------------------------------
module mem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  num_words,
  input  logic [31:0] expected_sum,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_resetn
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    READ,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [8:0]  index;
  logic [8:0]  num_q;
  logic [31:0] exp_q;
  logic [31:0] wsum;
  logic [31:0] rsum;
  logic [31:0] wait_cnt;

  logic        last_word;
  logic        wait_expired;
  logic        len_bad;
  logic [31:0] word_addr;

  // The bus is only ever used for data, never for instruction fetches.
  assign mem_instr = 1'b0;

  assign last_word    = (index == num_q - 9'd1);
  assign wait_expired = (wait_cnt == TIMEOUT - 32'd1);
  assign len_bad      = (num_words == 9'd0) || ({23'd0, num_words} > MAX_WORDS);
  assign word_addr    = BASE_ADDR + {21'd0, index, 2'b00};

  // Single FSM that registers every output. Bus fields are loaded only when
  // a request is launched and are not touched while mem_valid waits, so they
  // stay stable until the handshake completes. mem_valid always falls for
  // at least one cycle after a completion. Successive reads use a READ cycle
  // with mem_valid low as that gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      index       <= 9'd0;
      num_q       <= 9'd0;
      exp_q       <= 32'd0;
      wsum        <= 32'd0;
      rsum        <= 32'd0;
      wait_cnt    <= 32'd0;
      in_ready    <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_wstrb   <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      core_resetn <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            core_resetn <= 1'b0;
            num_q       <= num_words;
            exp_q       <= expected_sum;
            index       <= 9'd0;
            wsum        <= 32'd0;
            rsum        <= 32'd0;
            wait_cnt    <= 32'd0;
            if (len_bad) begin
              // error stays low for one cycle so the clear is visible, then
              // the ERR branch below raises it.
              state <= ERR;
            end else begin
              state    <= FETCH;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end else if (state == ERR) begin
            error <= 1'b1;
          end
        end

        FETCH: begin
          if (in_valid && in_ready) begin
            wsum      <= wsum + in_data;
            in_ready  <= 1'b0;
            mem_valid <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= in_data;
            mem_wstrb <= 4'hF;
            wait_cnt  <= 32'd0;
            state     <= WRITE;
          end
        end

        WRITE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            wait_cnt  <= 32'd0;
            if (last_word) begin
              index <= 9'd0;
              state <= READ;
            end else begin
              index    <= index + 9'd1;
              in_ready <= 1'b1;
              state    <= FETCH;
            end
          end else if (wait_expired) begin
            mem_valid <= 1'b0;
            wait_cnt  <= 32'd0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        READ: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'h0;
            wait_cnt  <= 32'd0;
          end else if (mem_ready) begin
            rsum      <= rsum + mem_rdata;
            mem_valid <= 1'b0;
            wait_cnt  <= 32'd0;
            if (last_word) begin
              state <= CHECK;
            end else begin
              index <= index + 9'd1;
            end
          end else if (wait_expired) begin
            mem_valid <= 1'b0;
            wait_cnt  <= 32'd0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        CHECK: begin
          busy <= 1'b0;
          if ((wsum == rsum) && (rsum == exp_q)) begin
            done        <= 1'b1;
            core_resetn <= 1'b1;
            state       <= DONE;
          end else begin
            error <= 1'b1;
            state <= ERR;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_boot_loader.md
MEM_BOOT_LOADER -- requirements
Module: mem_boot_loader

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h00000000, giving the byte address of word 0 of the image.
REQ-002 The module SHALL have parameter MAX_WORDS, default 256, giving the largest legal image length in words.
REQ-003 The module SHALL have parameter TIMEOUT, default 1024, giving the maximum cycles mem_valid may wait for mem_ready.
REQ-004 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  single-cycle load request.
REQ-007 Port num_words  input  9  image length in words, sampled on an accepted start.
REQ-008 Port expected_sum  input  32  expected mod-2^32 word sum, sampled on an accepted start.
REQ-009 Port in_valid / in_ready / in_data  input 1 / output 1 / input 32  image word stream.
REQ-010 Port mem_valid / mem_instr / mem_ready  output 1 / output 1 / input 1  memory bus handshake (initiator side).
REQ-011 Port mem_addr / mem_wdata / mem_wstrb / mem_rdata  output 32 / output 32 / output 4 / input 32  memory bus address, write data, byte strobes, read data.
REQ-012 Port busy / done / error / core_resetn  output 1 each  status and the CPU reset release.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, WRITE, READ, CHECK, DONE and ERR.
REQ-014 A start SHALL be accepted in IDLE, DONE or ERR, and SHALL be ignored in every other state.
REQ-015 On accept, if num_words is 0 or greater than MAX_WORDS, the FSM SHALL go to ERR; otherwise it SHALL go to FETCH with index=0, wsum=0 and rsum=0.
REQ-016 An accepted start SHALL clear done and error, and SHALL drive core_resetn=0, on the following cycle.
REQ-017 In FETCH, in_ready SHALL be 1; in every other state in_ready SHALL be 0.
REQ-018 When in_valid and in_ready are both 1, the FSM SHALL latch in_data, add it to wsum, and go to WRITE on the next cycle.
REQ-019 In WRITE, the block SHALL drive mem_valid=1, mem_addr=BASE_ADDR+4*index, mem_wdata=the latched word and mem_wstrb=4'hF.
REQ-020 In READ, the block SHALL drive mem_valid=1, mem_addr=BASE_ADDR+4*index and mem_wstrb=4'h0.
REQ-021 mem_instr SHALL be 0 at all times.
REQ-022 mem_addr, mem_wdata and mem_wstrb SHALL be held stable while mem_valid=1 and mem_ready=0.
REQ-023 A transfer SHALL complete on the cycle where mem_valid=1 and mem_ready=1; mem_valid SHALL be 0 on the next cycle, giving at least one idle cycle between transfers.
REQ-024 On a WRITE completion, if index==num_words-1 the FSM SHALL go to READ with index=0; otherwise it SHALL increment index and go to FETCH.
REQ-025 On a READ completion, the block SHALL add mem_rdata to rsum; if index==num_words-1 it SHALL go to CHECK, otherwise it SHALL increment index and issue the next read.
REQ-026 All sums SHALL wrap modulo 2^32.
REQ-027 CHECK SHALL last one cycle: it SHALL go to DONE if wsum==rsum==expected_sum, else to ERR.
REQ-028 In DONE, done=1 and core_resetn=1; in ERR, error=1 and core_resetn=0; both states SHALL hold until reset or an accepted start.
REQ-029 busy SHALL be 1 in FETCH, WRITE, READ and CHECK, and 0 otherwise.
REQ-030 A wait counter SHALL count the cycles in which mem_valid=1 and mem_ready=0; when it reaches TIMEOUT, mem_valid SHALL drop and the FSM SHALL go to ERR on that edge.
REQ-031 The wait counter SHALL clear on every completed transfer; FETCH SHALL have no timeout.
REQ-032 A mem_ready seen while mem_valid=0 SHALL be ignored.
REQ-033 No more than num_words words SHALL be taken from the stream; words offered in any other state SHALL be left untaken (in_ready=0).

Reset
REQ-034 When reset=1 at a rising edge, the block SHALL enter IDLE with index, wsum, rsum and the wait counter all at 0.
REQ-035 While in reset, outputs SHALL be mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, error=0 and core_resetn=0.
REQ-036 A reset during a pending bus transfer SHALL drop mem_valid on the next cycle; that transfer is abandoned and any later mem_ready for it SHALL be ignored.

Verification
REQ-037 The bench SHALL cover: 1-cycle-latency SRAM model; start with num_words=3, stream 0x11, 0x22, 0x33 and expected_sum=0x66 -> writes to addresses 0x0, 0x4 and 0x8 with wstrb=F, then three reads, then done=1 and core_resetn=1.
REQ-038 The bench SHALL cover: num_words=0, and separately num_words=257 -> error=1 on the second cycle after start, with no mem_valid ever asserted.
REQ-039 The bench SHALL cover: expected_sum=0x67 with the image of REQ-037 -> error=1 and core_resetn=0.
REQ-040 The bench SHALL cover: mem_ready stuck at 0 on the first write -> mem_valid held for exactly 1024 cycles, then error=1.
REQ-041 The bench SHALL cover: in_valid toggling randomly and mem_ready delayed 0 to 5 cycles -> correct addresses, stable bus signals during waits, and done=1.
REQ-042 The bench SHALL cover: reset asserted mid-WRITE with the bus held waiting -> next cycle mem_valid=0, busy=0 and core_resetn=0; a following start reloads correctly.
